group_serial_subtractor: RTL and testbench

Multi-cycle WIDTH-bit subtractor computing D = A − B − BIN one 4-bit group per clock, using a 4-bit borrow-lookahead network inside each group and a registered borrow between groups. It is the subtraction counterpart of the team's 4-bit carry-lookahead adder datapath. It serves area-constrained paths that can tolerate multi-cycle latency. Operands arrive and results leave through independent valid/ready handshakes.

---
 rtl/group_serial_subtractor.sv | 135 +++++++++++++
 tb/tb_group_serial_subtractor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/group_serial_subtractor.sv
// Purpose: WIDTH-bit subtractor D = A - B - BIN, one 4-bit borrow-lookahead group per clock.
// Latency: N = WIDTH/4 cycles from the accept edge to OUT_VALID; minimum issue interval N+2.
// Backpressure: the result is held in DONE until OUT_READY; IN_READY is high only in IDLE.
module group_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             ZERO,
    output logic             OVF
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Captured operands travel together so the accept edge is a single assignment.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    state_t           state;
    state_t           state_nxt;
    opnd_t            op_q;
    logic             bw_q;
    logic [KW-1:0]    k_q;
    logic             last_grp;

    logic [3:0]       ga;
    logic [3:0]       gb;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       bw;
    logic [3:0]       gd;
    logic [WIDTH-1:0] d_new;

    assign last_grp = (k_q == K_LAST);

    // Current group: flat sum-of-products borrow lookahead, no ripple inside the group.
    always_comb begin
        ga    = op_q.a[{k_q, 2'b00} +: 4];
        gb    = op_q.b[{k_q, 2'b00} +: 4];
        g     = ~ga & gb;
        p     = ~(ga ^ gb);
        bw[0] = bw_q;
        bw[1] = g[0] | (p[0] & bw_q);
        bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bw_q);
        bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bw_q);
        bw[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bw_q);
        gd    = ga ^ gb ^ bw[3:0];
        d_new = D;
        d_new[{k_q, 2'b00} +: 4] = gd;
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_nxt = RUN;
            end
            RUN: begin
                if (last_grp) state_nxt = DONE;
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, one group per RUN cycle, flags on the DONE-entry edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q <= '0;
            bw_q <= 1'b0;
            k_q  <= '0;
            D    <= '0;
            BOUT <= 1'b0;
            ZERO <= 1'b0;
            OVF  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        op_q.a <= A;
                        op_q.b <= B;
                        bw_q   <= BIN;
                        k_q    <= '0;
                    end
                end
                RUN: begin
                    D    <= d_new;
                    bw_q <= bw[4];
                    if (last_grp) begin
                        BOUT <= bw[4];
                        ZERO <= (d_new == '0);
                        OVF  <= (op_q.a[WIDTH-1] ^ op_q.b[WIDTH-1])
                              & (d_new[WIDTH-1] ^ op_q.a[WIDTH-1]);
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_group_serial_subtractor.sv
// Purpose: self-checking bench for group_serial_subtractor (WIDTH=16).
// Latency: expects OUT_VALID exactly 4 edges after the accept edge.
// Backpressure: exercises a held DONE state, mid-operation reset and random consumer delays.
module tb_group_serial_subtractor;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] A;
    logic [15:0] B;
    logic        BIN;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] D;
    logic        BOUT;
    logic        ZERO;
    logic        OVF;

    int n_cmp = 0;
    int n_bad = 0;

    group_serial_subtractor #(.WIDTH(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .B        (B),
        .BIN      (BIN),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .D        (D),
        .BOUT     (BOUT),
        .ZERO     (ZERO),
        .OVF      (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bout;
        logic        zero;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for borrow, signed range for overflow.
    task automatic ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bin,
                           output logic [15:0] d, output logic bout, output logic zero,
                           output logic ovf);
        int ud;
        int sd;
        ud   = int'({16'd0, a}) - int'({16'd0, b}) - int'({31'd0, bin});
        sd   = int'($signed(a)) - int'($signed(b)) - int'({31'd0, bin});
        d    = ud[15:0];
        bout = (ud < 0);
        zero = (d == 16'd0);
        ovf  = (sd > 32767) || (sd < -32768);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one operation, measure latency, hold the result for 'hold' cycles, then consume it.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input int hold,
                         output logic [15:0] d, output logic bout, output logic zero,
                         output logic ovf, output int lat);
        int w;
        w = 0;
        while (!IN_READY && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_before_issue", {31'd0, IN_READY}, 32'd1);
        IN_VALID = 1'b1;
        A        = a;
        B        = b;
        BIN      = bin;
        tick();
        IN_VALID = 1'b0;
        A        = 16'($urandom);
        B        = 16'($urandom);
        BIN      = 1'($urandom);
        check("in_ready_after_accept", {31'd0, IN_READY}, 32'd0);
        lat = 0;
        while (!OUT_VALID && lat < 20) begin
            tick();
            lat++;
        end
        repeat (hold) tick();
        d    = D;
        bout = BOUT;
        zero = ZERO;
        ovf  = OVF;
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("in_ready_after_consume", {31'd0, IN_READY}, 32'd1);
        check("out_valid_after_consume", {31'd0, OUT_VALID}, 32'd0);
    endtask

    logic [15:0] rd;
    logic        rbout;
    logic        rzero;
    logic        rovf;
    int          rlat;
    logic [15:0] ed;
    logic        ebout;
    logic        ezero;
    logic        eovf;

    initial begin
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};

        RST       = 1'b1;
        IN_VALID  = 1'b0;
        A         = 16'h0;
        B         = 16'h0;
        BIN       = 1'b0;
        OUT_READY = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_d", {16'd0, D}, 32'd0);
        check("rst_flags", {29'd0, BOUT, ZERO, OVF}, 32'd0);
        repeat (2) tick();
        RST = 1'b0;
        tick();

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0, rd, rbout, rzero, rovf, rlat);
            check($sformatf("vec%0d_latency", i), rlat, 32'd4);
            check($sformatf("vec%0d_d", i), {16'd0, rd}, {16'd0, vecs[i].d});
            check($sformatf("vec%0d_bout", i), {31'd0, rbout}, {31'd0, vecs[i].bout});
            check($sformatf("vec%0d_zero", i), {31'd0, rzero}, {31'd0, vecs[i].zero});
            check($sformatf("vec%0d_ovf", i), {31'd0, rovf}, {31'd0, vecs[i].ovf});
        end

        // Backpressure: DONE held for 5 cycles while new operands are offered.
        IN_VALID = 1'b1;
        A        = 16'h1234;
        B        = 16'h0234;
        BIN      = 1'b0;
        tick();
        IN_VALID = 1'b0;
        rlat = 0;
        while (!OUT_VALID && rlat < 20) begin
            tick();
            rlat++;
        end
        check("bp_latency", rlat, 32'd4);
        for (int c = 0; c < 5; c++) begin
            IN_VALID = 1'b1;
            A        = 16'($urandom);
            B        = 16'($urandom);
            BIN      = 1'($urandom);
            tick();
            check("bp_d", {16'd0, D}, 32'h1000);
            check("bp_flags", {29'd0, BOUT, ZERO, OVF}, 32'd0);
            check("bp_in_ready", {31'd0, IN_READY}, 32'd0);
            check("bp_out_valid", {31'd0, OUT_VALID}, 32'd1);
        end
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("bp_release_in_ready", {31'd0, IN_READY}, 32'd1);
        check("bp_release_out_valid", {31'd0, OUT_VALID}, 32'd0);

        // Reset after two RUN cycles.
        IN_VALID = 1'b1;
        A        = 16'hFFFF;
        B        = 16'h0001;
        BIN      = 1'b0;
        tick();
        IN_VALID = 1'b0;
        repeat (2) tick();
        RST = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("midrst_d", {16'd0, D}, 32'd0);
        check("midrst_in_ready", {31'd0, IN_READY}, 32'd1);
        tick();
        RST = 1'b0;
        #2;
        do_op(16'h0010, 16'h0001, 1'b0, 0, rd, rbout, rzero, rovf, rlat);
        check("postrst_latency", rlat, 32'd4);
        check("postrst_d", {16'd0, rd}, 32'h000F);
        check("postrst_flags", {29'd0, rbout, rzero, rovf}, 32'd0);

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 150; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rbin;
            ra   = 16'($urandom);
            rb   = (i % 8 == 0) ? ra : 16'($urandom);
            rbin = 1'($urandom);
            ref_sub(ra, rb, rbin, ed, ebout, ezero, eovf);
            do_op(ra, rb, rbin, int'($urandom_range(0, 2)), rd, rbout, rzero, rovf, rlat);
            check("rnd_latency", rlat, 32'd4);
            check("rnd_d", {16'd0, rd}, {16'd0, ed});
            check("rnd_bout", {31'd0, rbout}, {31'd0, ebout});
            check("rnd_zero", {31'd0, rzero}, {31'd0, ezero});
            check("rnd_ovf", {31'd0, rovf}, {31'd0, eovf});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
